trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap sequencer sitting between the pipeline and the machine CSR file.
- Arbitrates synchronous exceptions, pending machine interrupts and MRET.
- Produces the one-cycle trap-entry strobe with the exception PC, cause and trap value that the CSR file latches into mepc/mcause/mtval.
- Flushes the pipeline and issues the fetch redirect (trap vector or mepc) via a valid/ready handshake.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles flush_o is held asserted (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  reset; asynchronous, active-high
exc_valid_i  input  1  synchronous exception reported by execute stage
exc_cause_i  input  5  exception code (0..31)
exc_pc_i  input  32  PC of faulting instruction
exc_tval_i  input  32  trap value for exception
mret_i  input  1  MRET retiring
int_window_i  input  1  instruction boundary; interrupt may be taken
instr_pc_i  input  32  PC of next instruction to execute (interrupt epc)
mstatus_mie_i  input  1  global machine interrupt enable
mie_i  input  32  mie CSR
mip_i  input  32  mip CSR
trap_base_addr_i  input  32  mtvec base, low 2 bits zero
trap_mode_i  input  2  mtvec mode
mepc_i  input  32  mepc CSR (MRET target)
redirect_ready_i  input  1  fetch accepts redirect
trap_take_o  output  1  one-cycle strobe: CSR file latches trap state
exception_pc_o  output  32  epc for CSR file, bit0 forced 0
trap_cause_o  output  32  mcause value
trap_val_o  output  32  mtval value
mret_take_o  output  1  one-cycle strobe: CSR file restores mstatus
flush_o  output  1  kill all in-flight instructions
redirect_valid_o  output  1  redirect_pc_o valid
redirect_pc_o  output  32  new fetch PC
busy_o  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal counter 0. Reset mid-sequence aborts it immediately; no redirect issued.
- States: IDLE, FLUSH, REDIRECT.
- Event arbitration in IDLE, sampled at the clock edge, priority:
  - exc_valid_i
  - then mret_i
  - then interrupt: irq = mstatus_mie_i & int_window_i & |(mie_i & mip_i)
- Interrupt priority: MEI (bit 11) > MSI (bit 3) > MTI (bit 7). Other bits are ignored.
- Exception: cause = {27'b0, exc_cause_i}; epc = exc_pc_i & ~1; tval = exc_tval_i.
- Interrupt: cause = {1'b1, 26'b0, code}, where code is 11, 3 or 7; epc = instr_pc_i & ~1; tval = 0.
- Trap: IDLE -> FLUSH on the accepting edge.
  - trap_take_o = 1 for exactly the first FLUSH cycle.
  - cause/epc/tval are registered on that edge and held stable until the next accepted event.
- MRET: IDLE -> FLUSH. mret_take_o = 1 for the first FLUSH cycle; target = mepc_i sampled on the accepting edge.
- FLUSH: flush_o = 1 for exactly FLUSH_CYCLES cycles, then -> REDIRECT.
- REDIRECT: redirect_valid_o = 1 and redirect_pc_o stable until redirect_ready_i = 1 at a clock edge, then -> IDLE (valid drops next cycle). flush_o = 0 in REDIRECT.
- Trap target:
  - Direct (mode 00, or reserved 1x): trap_base_addr_i.
  - Mode 01 with interrupt: see Optional Feature.
  - Target is computed from trap_base_addr_i and trap_mode_i sampled on the accepting edge.
- Latency: event at edge N -> trap_take_o in cycle N+1 -> redirect_valid_o first high in cycle N+1+FLUSH_CYCLES.
- Events arriving while busy_o = 1 are ignored; the pipeline holds them.
- Simultaneous exception and MRET: the exception wins and the MRET is dropped.
- Address arithmetic is 32-bit modulo with no overflow detection.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: mode 01 with interrupt -> target = trap_base_addr_i + 4*code (32-bit add). Exceptions in mode 01 use the base.
- Undefined: mode 01 is treated as direct; all traps go to trap_base_addr_i.

Test Plan:
- Exception: exc_valid_i, cause 2, pc 0x0000_1003, tval 0xDEAD_BEEF, base 0x0000_0100 -> trap_take_o 1 cycle, epc 0x1002, cause 0x2, tval 0xDEADBEEF, flush 2 cycles, redirect 0x100.
- Interrupt priority: mip = mie = 0x888, MIE = 1, window = 1, mode 01, base 0x200 -> cause 0x8000_000B; redirect 0x22C with TRAP_VECTORED_EN, 0x200 without.
- Gating: pending MTI with mstatus_mie_i = 0 or int_window_i = 0 -> no strobe, busy_o stays 0 for 10 cycles.
- MRET: mret_i with mepc_i 0x0000_4000 -> mret_take_o 1 cycle, trap_take_o 0, redirect 0x4000. redirect_ready_i low 3 cycles -> valid/pc held, IDLE after the ready edge.
- Collision/busy: exc_valid_i and mret_i in the same cycle -> trap only. A second exc_valid_i during FLUSH is ignored (single trap_take_o).
- Async reset asserted in REDIRECT between edges -> all outputs 0 immediately; after release, a new exception is accepted normally.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, machine interrupts and MRET, then flushes and redirects fetch.
// Optional vectored interrupt targets in mtvec mode 01 are enabled by defining TRAP_VECTORED_EN.
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        int_window_i,
    input  logic [31:0] instr_pc_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mip_i,
    input  logic [31:0] trap_base_addr_i,
    input  logic [1:0]  trap_mode_i,
    input  logic [31:0] mepc_i,
    input  logic        redirect_ready_i,
    output logic        trap_take_o,
    output logic [31:0] exception_pc_o,
    output logic [31:0] trap_cause_o,
    output logic [31:0] trap_val_o,
    output logic        mret_take_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        trap_take_q, trap_take_d;
    logic        mret_take_q, mret_take_d;
    logic        flush_q, flush_d;
    logic        redir_valid_q, redir_valid_d;
    logic        busy_q, busy_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [31:0] pend_s;
    logic [3:0]  irq_code_s;
    logic        irq_req_s;
    logic [31:0] irq_target_s;
    logic        unused_s;

    assign pend_s = mie_i & mip_i;

    // Fixed interrupt priority: MEI, then MSI, then MTI; all other pending bits are ignored.
    always_comb begin
        irq_code_s = 4'd0;
        if (pend_s[11]) begin
            irq_code_s = 4'd11;
        end else if (pend_s[3]) begin
            irq_code_s = 4'd3;
        end else if (pend_s[7]) begin
            irq_code_s = 4'd7;
        end else begin
            irq_code_s = 4'd0;
        end
    end

    assign irq_req_s = mstatus_mie_i & int_window_i & (pend_s[11] | pend_s[3] | pend_s[7]);

`ifdef TRAP_VECTORED_EN
    assign irq_target_s = (trap_mode_i == 2'b01)
                        ? trap_base_addr_i + {26'd0, irq_code_s, 2'b00}
                        : trap_base_addr_i;
    assign unused_s     = ^{pend_s[31:12], pend_s[10:8], pend_s[6:4], pend_s[2:0]};
`else
    assign irq_target_s = trap_base_addr_i;
    assign unused_s     = ^{pend_s[31:12], pend_s[10:8], pend_s[6:4], pend_s[2:0], trap_mode_i};
`endif

    // Next-state and next-output logic for the IDLE/FLUSH/REDIRECT sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        trap_take_d   = 1'b0;
        mret_take_d   = 1'b0;
        flush_d       = flush_q;
        redir_valid_d = redir_valid_q;
        busy_d        = busy_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        tval_d        = tval_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LAST;
                    flush_d     = 1'b1;
                    busy_d      = 1'b1;
                    trap_take_d = 1'b1;
                    cause_d     = {27'd0, exc_cause_i};
                    epc_d       = exc_pc_i & 32'hFFFF_FFFE;
                    tval_d      = exc_tval_i;
                    redir_pc_d  = trap_base_addr_i;
                end else if (mret_i) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LAST;
                    flush_d     = 1'b1;
                    busy_d      = 1'b1;
                    mret_take_d = 1'b1;
                    redir_pc_d  = mepc_i;
                end else if (irq_req_s) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LAST;
                    flush_d     = 1'b1;
                    busy_d      = 1'b1;
                    trap_take_d = 1'b1;
                    cause_d     = {1'b1, 27'd0, irq_code_s};
                    epc_d       = instr_pc_i & 32'hFFFF_FFFE;
                    tval_d      = 32'd0;
                    redir_pc_d  = irq_target_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d       = ST_REDIRECT;
                    flush_d       = 1'b0;
                    redir_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) begin
                    state_d       = ST_IDLE;
                    redir_valid_d = 1'b0;
                    busy_d        = 1'b0;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                cnt_d         = 4'd0;
                flush_d       = 1'b0;
                redir_valid_d = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            trap_take_q   <= 1'b0;
            mret_take_q   <= 1'b0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            epc_q         <= 32'd0;
            cause_q       <= 32'd0;
            tval_q        <= 32'd0;
            redir_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trap_take_q   <= trap_take_d;
            mret_take_q   <= mret_take_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            busy_q        <= busy_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign trap_take_o      = trap_take_q;
    assign mret_take_o      = mret_take_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign busy_o           = busy_q;
    assign exception_pc_o   = epc_q;
    assign trap_cause_o     = cause_q;
    assign trap_val_o       = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: cycle-timeline reference model plus directed scenarios.
module tb_trap_ctrl;

    localparam int FLUSH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_cause_i = 5'd0;
    logic [31:0] exc_pc_i = 32'd0;
    logic [31:0] exc_tval_i = 32'd0;
    logic        mret_i = 1'b0;
    logic        int_window_i = 1'b0;
    logic [31:0] instr_pc_i = 32'd0;
    logic        mstatus_mie_i = 1'b0;
    logic [31:0] mie_i = 32'd0;
    logic [31:0] mip_i = 32'd0;
    logic [31:0] trap_base_addr_i = 32'd0;
    logic [1:0]  trap_mode_i = 2'b00;
    logic [31:0] mepc_i = 32'd0;
    logic        redirect_ready_i = 1'b1;
    logic        trap_take_o, mret_take_o, flush_o, redirect_valid_o, busy_o;
    logic [31:0] exception_pc_o, trap_cause_o, trap_val_o, redirect_pc_o;

    int n_cmp = 0;
    int n_bad = 0;

    trap_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .reset(reset),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .mret_i(mret_i), .int_window_i(int_window_i),
        .instr_pc_i(instr_pc_i), .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mip_i(mip_i),
        .trap_base_addr_i(trap_base_addr_i), .trap_mode_i(trap_mode_i), .mepc_i(mepc_i),
        .redirect_ready_i(redirect_ready_i), .trap_take_o(trap_take_o),
        .exception_pc_o(exception_pc_o), .trap_cause_o(trap_cause_o), .trap_val_o(trap_val_o),
        .mret_take_o(mret_take_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the edge at which an event was accepted and derives
    // every output from the distance between the current cycle and that edge.
    int unsigned edge_n, m_acc;
    logic        m_active, m_is_mret;
    logic [31:0] m_cause, m_epc, m_tval, m_target;

    function automatic int irq_code(input logic [31:0] p);
        if (p[11]) return 11;
        if (p[3])  return 3;
        if (p[7])  return 7;
        return 0;
    endfunction

    function automatic logic [31:0] model_target(input logic is_irq, input int code);
`ifdef TRAP_VECTORED_EN
        if (is_irq && trap_mode_i == 2'b01) return trap_base_addr_i + 32'(4 * code);
`endif
        return trap_base_addr_i;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_n <= 0; m_acc <= 0; m_active <= 1'b0; m_is_mret <= 1'b0;
            m_cause <= 32'd0; m_epc <= 32'd0; m_tval <= 32'd0; m_target <= 32'd0;
        end else begin
            edge_n <= edge_n + 1;
            if (m_active) begin
                if (edge_n >= m_acc + FLUSH && redirect_ready_i) m_active <= 1'b0;
            end else if (exc_valid_i) begin
                m_active <= 1'b1; m_acc <= edge_n + 1; m_is_mret <= 1'b0;
                m_cause <= {27'd0, exc_cause_i};
                m_epc <= exc_pc_i & 32'hFFFF_FFFE;
                m_tval <= exc_tval_i;
                m_target <= model_target(1'b0, 0);
            end else if (mret_i) begin
                m_active <= 1'b1; m_acc <= edge_n + 1; m_is_mret <= 1'b1;
                m_target <= mepc_i;
            end else if (mstatus_mie_i && int_window_i && irq_code(mie_i & mip_i) != 0) begin
                m_active <= 1'b1; m_acc <= edge_n + 1; m_is_mret <= 1'b0;
                m_cause <= 32'h8000_0000 | 32'(irq_code(mie_i & mip_i));
                m_epc <= instr_pc_i & 32'hFFFF_FFFE;
                m_tval <= 32'd0;
                m_target <= model_target(1'b1, irq_code(mie_i & mip_i));
            end
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        chk("trap_take", {31'd0, trap_take_o}, {31'd0, m_active && !m_is_mret && edge_n == m_acc});
        chk("mret_take", {31'd0, mret_take_o}, {31'd0, m_active && m_is_mret && edge_n == m_acc});
        chk("flush", {31'd0, flush_o}, {31'd0, m_active && edge_n < m_acc + FLUSH});
        chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, m_active && edge_n >= m_acc + FLUSH});
        chk("busy", {31'd0, busy_o}, {31'd0, m_active});
        chk("cause", trap_cause_o, m_cause);
        chk("epc", exception_pc_o, m_epc);
        chk("tval", trap_val_o, m_tval);
        if (m_active && edge_n >= m_acc + FLUSH) chk("redirect_pc", redirect_pc_o, m_target);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] exp_vec;

    initial begin
        step(2);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_redirect_pc", redirect_pc_o, 32'd0);
        reset = 1'b0;
        step(2);

        // Exception with misaligned PC, direct mode.
        exc_valid_i = 1'b1; exc_cause_i = 5'd2; exc_pc_i = 32'h0000_1003;
        exc_tval_i = 32'hDEAD_BEEF; trap_base_addr_i = 32'h0000_0100; trap_mode_i = 2'b00;
        step(1);
        exc_valid_i = 1'b0;
        chk("exc_take", {31'd0, trap_take_o}, 32'd1);
        chk("exc_epc", exception_pc_o, 32'h0000_1002);
        chk("exc_cause", trap_cause_o, 32'h0000_0002);
        chk("exc_tval", trap_val_o, 32'hDEAD_BEEF);
        step(1);
        chk("exc_flush2", {31'd0, flush_o}, 32'd1);
        step(1);
        chk("exc_flush_off", {31'd0, flush_o}, 32'd0);
        chk("exc_redirect", redirect_pc_o, 32'h0000_0100);
        step(1);
        chk("exc_idle", {31'd0, busy_o}, 32'd0);
        step(1);

        // Three interrupts pending: MEI must win.
        mie_i = 32'h888; mip_i = 32'h888; mstatus_mie_i = 1'b1; int_window_i = 1'b1;
        trap_mode_i = 2'b01; trap_base_addr_i = 32'h0000_0200; instr_pc_i = 32'h0000_3001;
        step(1);
        mip_i = 32'd0;
        chk("irq_take", {31'd0, trap_take_o}, 32'd1);
        chk("irq_cause", trap_cause_o, 32'h8000_000B);
        chk("irq_epc", exception_pc_o, 32'h0000_3000);
        step(2);
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h0000_022C;
`else
        exp_vec = 32'h0000_0200;
`endif
        chk("irq_redirect", redirect_pc_o, exp_vec);
        step(2);

        // Pending MTI gated by global enable, then by the instruction window.
        mie_i = 32'h80; mip_i = 32'h80; mstatus_mie_i = 1'b0; int_window_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("gate_mie", {31'd0, busy_o}, 32'd0);
        end
        mstatus_mie_i = 1'b1; int_window_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("gate_window", {31'd0, busy_o}, 32'd0);
        end
        mip_i = 32'd0; mie_i = 32'd0;

        // MRET with back-pressure on the redirect.
        redirect_ready_i = 1'b0; mret_i = 1'b1; mepc_i = 32'h0000_4000;
        step(1);
        mret_i = 1'b0;
        chk("mret_take", {31'd0, mret_take_o}, 32'd1);
        chk("mret_no_trap", {31'd0, trap_take_o}, 32'd0);
        step(2);
        for (int i = 0; i < 3; i++) begin
            chk("mret_hold_valid", {31'd0, redirect_valid_o}, 32'd1);
            chk("mret_hold_pc", redirect_pc_o, 32'h0000_4000);
            if (i < 2) step(1);
        end
        redirect_ready_i = 1'b1;
        step(1);
        chk("mret_valid_drop", {31'd0, redirect_valid_o}, 32'd0);
        chk("mret_idle", {31'd0, busy_o}, 32'd0);
        step(1);

        // Exception and MRET together; a later exception while busy is ignored.
        exc_valid_i = 1'b1; mret_i = 1'b1; exc_cause_i = 5'd5; exc_pc_i = 32'h0000_2000;
        exc_tval_i = 32'h0000_0011; trap_mode_i = 2'b00;
        step(1);
        mret_i = 1'b0; exc_cause_i = 5'd7;
        chk("coll_trap", {31'd0, trap_take_o}, 32'd1);
        chk("coll_no_mret", {31'd0, mret_take_o}, 32'd0);
        chk("coll_cause", trap_cause_o, 32'h0000_0005);
        step(1);
        exc_valid_i = 1'b0;
        chk("busy_ignored", {31'd0, trap_take_o}, 32'd0);
        chk("busy_cause", trap_cause_o, 32'h0000_0005);
        step(3);

        // Asynchronous reset while waiting in REDIRECT.
        redirect_ready_i = 1'b0; exc_valid_i = 1'b1; exc_cause_i = 5'd1;
        exc_pc_i = 32'h0000_0600; exc_tval_i = 32'h0000_0033;
        step(1);
        exc_valid_i = 1'b0;
        step(2);
        chk("pre_reset_valid", {31'd0, redirect_valid_o}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", {31'd0, redirect_valid_o}, 32'd0);
        chk("areset_busy", {31'd0, busy_o}, 32'd0);
        chk("areset_pc", redirect_pc_o, 32'd0);
        chk("areset_cause", trap_cause_o, 32'd0);
        step(1);
        reset = 1'b0; redirect_ready_i = 1'b1;
        step(1);
        exc_valid_i = 1'b1; exc_cause_i = 5'd4; exc_pc_i = 32'h0000_0505; exc_tval_i = 32'd0;
        step(1);
        exc_valid_i = 1'b0;
        chk("post_reset_take", {31'd0, trap_take_o}, 32'd1);
        chk("post_reset_epc", exception_pc_o, 32'h0000_0504);
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
